// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-CTR AXI4-Lite register front-end.
package aes_ctr_pkg;

  // Register word indices (byte offset = index * 4, decoded from addr[5:2])
  localparam logic [3:0] IDX_CTRL    = 4'h0;
  localparam logic [3:0] IDX_DATA0   = 4'h1;
  localparam logic [3:0] IDX_KEY0    = 4'h5;
  localparam logic [3:0] IDX_NONCE0  = 4'h9;
  localparam logic [3:0] IDX_STATUS  = 4'hB;
  localparam logic [3:0] IDX_RESULT0 = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // RESULT[0..3] occupy the top four word slots and are read-only
  function automatic logic is_ro(input logic [3:0] idx);
    return idx >= IDX_RESULT0;
  endfunction

endpackage

// File: rtl/aes_ctr_axil_regs_if.sv
// AXI4-Lite bus bundle between the interconnect and the AES-CTR register block.
interface aes_ctr_axil_regs_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_wr_ctrl.sv
// AXI4-Lite write channel: joint AW/W acceptance, B response, byte-strobe merge.
module axil_wr_ctrl
  import aes_ctr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] cur_word,
  input  logic        wr_slverr,
  output logic        wr_en,
  output logic [31:0] wr_data
);

  wr_state_t  state;
  logic [1:0] bresp_q;
  logic       accept;

  // AW and W are only taken together; gating with rst_n keeps ready low in reset
  assign accept  = rst_n && (state == W_IDLE) && awvalid && wvalid;
  assign awready = accept;
  assign wready  = accept;
  assign wr_en   = accept;
  assign bvalid  = (state == W_RESP);
  assign bresp   = bresp_q;

  // Merge enabled byte lanes of the write data over the addressed register
  always_comb begin
    wr_data = cur_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb[i]) wr_data[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Write channel FSM: response registered at acceptance, held until bready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= W_IDLE;
      bresp_q <= RESP_OKAY;
    end else begin
      case (state)
        W_IDLE: if (accept) begin
          state   <= W_RESP;
          bresp_q <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
        end
        W_RESP: if (bready) state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_ctr_axil_regs.sv
// AXI4-Lite register front-end for the AES-CTR core: key/nonce/block, start, result.
module aes_ctr_axil_regs
  import aes_ctr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                aclk,
  input  logic                aresetn,
  aes_ctr_axil_regs_if.slave  s_axi,
  output logic [127:0]        core_key,
  output logic [63:0]         core_nonce,
  output logic [127:0]        core_block,
  output logic                core_next,
  input  logic                core_ready,
  input  logic [127:0]        core_result,
  input  logic                core_result_valid
);

  logic [31:0] data_in [4];
  logic [31:0] key     [4];
  logic [31:0] nonce   [2];
  logic [31:0] result  [4];
  logic        result_valid;
  logic        start_err;

  logic [3:0]            aw_idx, ar_idx;
  logic [ADDR_WIDTH-1:0] aw_hi, ar_hi;
  logic                  aw_mapped, ar_mapped;
  logic                  wr_en, wr_slverr, start_req;
  logic [31:0]           wr_cur, wr_data, rd_word;

  rd_state_t   rd_state;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        unused_ok;

  assign aw_idx    = s_axi.awaddr[5:2];
  assign ar_idx    = s_axi.araddr[5:2];
  assign aw_hi     = s_axi.awaddr >> 6;
  assign ar_hi     = s_axi.araddr >> 6;
  assign aw_mapped = (aw_hi == '0);
  assign ar_mapped = (ar_hi == '0);
  assign wr_slverr = !aw_mapped || is_ro(aw_idx);
  assign start_req = wr_en && aw_mapped && (aw_idx == IDX_CTRL) &&
                     s_axi.wstrb[0] && s_axi.wdata[0];

  assign unused_ok = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot, s_axi.arprot};

  assign core_key   = {key[0], key[1], key[2], key[3]};
  assign core_nonce = {nonce[0], nonce[1]};
  assign core_block = {data_in[0], data_in[1], data_in[2], data_in[3]};

  // Readback value of one register word; CTRL and unused slots read as zero
  function automatic logic [31:0] reg_word(input logic [3:0] idx);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (idx == 4'(IDX_DATA0 + i))   v = data_in[i];
      if (idx == 4'(IDX_KEY0 + i))    v = key[i];
      if (idx == 4'(IDX_RESULT0 + i)) v = result[i];
    end
    for (int unsigned i = 0; i < 2; i++) begin
      if (idx == 4'(IDX_NONCE0 + i))  v = nonce[i];
    end
    if (idx == IDX_STATUS) v = {29'd0, start_err, result_valid, core_ready};
    return v;
  endfunction

  // Current contents at the write and read addresses
  always_comb begin
    wr_cur  = reg_word(aw_idx);
    rd_word = reg_word(ar_idx);
  end

  axil_wr_ctrl u_wr (
    .clk       (aclk),
    .rst_n     (aresetn),
    .awvalid   (s_axi.awvalid),
    .awready   (s_axi.awready),
    .wvalid    (s_axi.wvalid),
    .wready    (s_axi.wready),
    .wdata     (s_axi.wdata),
    .wstrb     (s_axi.wstrb),
    .bresp     (s_axi.bresp),
    .bvalid    (s_axi.bvalid),
    .bready    (s_axi.bready),
    .cur_word  (wr_cur),
    .wr_slverr (wr_slverr),
    .wr_en     (wr_en),
    .wr_data   (wr_data)
  );

  // Register file, start pulse and result capture; a start overrides a coincident result_valid set
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < 4; i++) begin
        data_in[i] <= '0;
        key[i]     <= '0;
        result[i]  <= '0;
      end
      nonce[0]     <= '0;
      nonce[1]     <= '0;
      result_valid <= 1'b0;
      start_err    <= 1'b0;
      core_next    <= 1'b0;
    end else begin
      core_next <= 1'b0;
      if (core_result_valid) begin
        for (int unsigned i = 0; i < 4; i++) result[i] <= core_result[127 - 32*i -: 32];
        result_valid <= 1'b1;
      end
      if (wr_en && aw_mapped) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (aw_idx == 4'(IDX_DATA0 + i)) data_in[i] <= wr_data;
          if (aw_idx == 4'(IDX_KEY0 + i))  key[i]     <= wr_data;
        end
        for (int unsigned i = 0; i < 2; i++) begin
          if (aw_idx == 4'(IDX_NONCE0 + i)) nonce[i] <= wr_data;
        end
        if (aw_idx == IDX_STATUS && s_axi.wstrb[0] && s_axi.wdata[2]) start_err <= 1'b0;
      end
      if (start_req) begin
        if (core_ready) begin
          core_next    <= 1'b1;
          result_valid <= 1'b0;
        end else begin
          start_err <= 1'b1;
        end
      end
    end
  end

  assign s_axi.arready = aresetn && (rd_state == R_IDLE);
  assign s_axi.rvalid  = (rd_state == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // Read channel FSM: data captured at acceptance, held until rready
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (s_axi.arvalid) begin
          rd_state <= R_DATA;
          rdata_q  <= ar_mapped ? rd_word : '0;
          rresp_q  <= ar_mapped ? RESP_OKAY : RESP_SLVERR;
        end
        R_DATA: if (s_axi.rready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ctr_axil_regs.sv
// Scoreboard bench for aes_ctr_axil_regs (7-bit address so 0x40+ is reachable).
module tb_aes_ctr_axil_regs;
  import aes_ctr_pkg::*;

  localparam int unsigned AW = 7;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [127:0] core_key, core_block, core_result;
  logic [63:0]  core_nonce;
  logic         core_next, core_ready, core_result_valid;

  aes_ctr_axil_regs_if #(.ADDR_WIDTH(AW)) s_axi ();

  aes_ctr_axil_regs #(.ADDR_WIDTH(AW)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axi             (s_axi),
    .core_key          (core_key),
    .core_nonce        (core_nonce),
    .core_block        (core_block),
    .core_next         (core_next),
    .core_ready        (core_ready),
    .core_result       (core_result),
    .core_result_valid (core_result_valid)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  int          checks = 0;
  int          failures = 0;
  int          next_cnt = 0;
  logic [1:0]  bq [$];
  rd_exp_t     rq [$];

  localparam logic [127:0] RES1 = 128'h874d6191_b620e326_1bef6864_990db6ce;
  localparam logic [127:0] RES2 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] RES3 = 128'hdeadbeef_01020304_05060708_090a0b0c;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected responses as the DUT completes B and R handshakes
  always @(negedge aclk) begin
    if (aresetn && s_axi.bvalid && s_axi.bready) begin
      if (bq.size() == 0) check("b_unexpected", 1, 0);
      else check("bresp", s_axi.bresp, bq.pop_front());
    end
    if (aresetn && s_axi.rvalid && s_axi.rready) begin
      if (rq.size() == 0) check("r_unexpected", 1, 0);
      else begin
        rd_exp_t e;
        e = rq.pop_front();
        check("rdata", s_axi.rdata, e.data);
        check("rresp", s_axi.rresp, e.resp);
      end
    end
    if (core_next) next_cnt++;
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp);
    int n;
    n = 0;
    bq.push_back(exp);
    s_axi.awaddr = addr; s_axi.wdata = data; s_axi.wstrb = strb;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
    #1;
    while (!(s_axi.awready && s_axi.wready) && n < 20) begin
      @(posedge aclk); #2; n++;
    end
    if (n == 20) begin
      check("aw_accept_timeout", s_axi.awready, 1);
      s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
      void'(bq.pop_back());
      @(posedge aclk); #1;
      return;
    end
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    check("bvalid_after_accept", s_axi.bvalid, 1);
    @(posedge aclk); #1;
    check("bvalid_cleared", s_axi.bvalid, 0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] data, input logic [1:0] resp);
    int n;
    rd_exp_t e;
    n = 0;
    e.data = data; e.resp = resp;
    rq.push_back(e);
    s_axi.araddr = addr; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
    #1;
    while (!s_axi.arready && n < 20) begin
      @(posedge aclk); #2; n++;
    end
    if (n == 20) begin
      check("ar_accept_timeout", s_axi.arready, 1);
      s_axi.arvalid = 1'b0;
      void'(rq.pop_back());
      @(posedge aclk); #1;
      return;
    end
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
    check("rvalid_after_accept", s_axi.rvalid, 1);
    s_axi.rready = 1'b1;
    @(posedge aclk); #1;
    s_axi.rready = 1'b0;
    check("rvalid_cleared", s_axi.rvalid, 0);
  endtask

  initial begin
    int n0;
    logic [31:0] key_w [4];
    logic [31:0] dat_w [4];
    key_w = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    dat_w = '{32'h6bc1bee2, 32'h2e409f96, 32'he93d7e11, 32'h7393172a};

    s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.wdata = '0; s_axi.wstrb = '0;
    s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arprot = '0; s_axi.rready = 1'b0;
    core_ready = 1'b1; core_result = '0; core_result_valid = 1'b0;
    aresetn = 1'b0;
    // Valids offered during reset must not be accepted
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.arvalid = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", s_axi.awready, 0);
    check("rst_wready", s_axi.wready, 0);
    check("rst_arready", s_axi.arready, 0);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_bresp", s_axi.bresp, 0);
    check("rst_rresp", s_axi.rresp, 0);
    check("rst_core_next", core_next, 0);
    check("rst_core_key", core_key, 0);
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Key and nonce load
    for (int i = 0; i < 4; i++) axi_write(7'(8'h14 + 4*i), key_w[i], 4'hf, RESP_OKAY);
    axi_write(7'h24, 32'h0, 4'hf, RESP_OKAY);
    axi_write(7'h28, 32'h0, 4'hf, RESP_OKAY);
    check("core_key", core_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("core_nonce", core_nonce, 0);
    axi_read(7'h1c, 32'habf71588, RESP_OKAY);

    // Start with core ready; core model answers the pulse with RES1
    for (int i = 0; i < 4; i++) axi_write(7'(8'h04 + 4*i), dat_w[i], 4'hf, RESP_OKAY);
    n0 = next_cnt;
    axi_write(7'h00, 32'h1, 4'hf, RESP_OKAY);
    axi_write(7'h00, 32'h0, 4'hf, RESP_OKAY);
    repeat (2) @(posedge aclk);
    #1;
    check("start_one_pulse", next_cnt - n0, 1);
    check("core_block", core_block, 128'h6bc1bee22e409f96e93d7e117393172a);
    if (next_cnt != n0) begin
      core_result = RES1; core_result_valid = 1'b1;
      @(posedge aclk); #1;
      core_result_valid = 1'b0;
    end
    axi_read(7'h30, 32'h874d6191, RESP_OKAY);
    axi_read(7'h34, 32'hb620e326, RESP_OKAY);
    axi_read(7'h38, 32'h1bef6864, RESP_OKAY);
    axi_read(7'h3c, 32'h990db6ce, RESP_OKAY);
    axi_read(7'h2c, 32'h3, RESP_OKAY);
    axi_read(7'h00, 32'h0, RESP_OKAY);

    // CTRL write with wstrb[0]=0 does not start
    n0 = next_cnt;
    axi_write(7'h00, 32'h1, 4'he, RESP_OKAY);
    check("ctrl_nostrb_no_pulse", next_cnt - n0, 0);

    // Busy reject and W1C of start_err
    core_ready = 1'b0;
    n0 = next_cnt;
    axi_write(7'h00, 32'h1, 4'hf, RESP_OKAY);
    repeat (2) @(posedge aclk);
    #1;
    check("busy_no_pulse", next_cnt - n0, 0);
    axi_read(7'h2c, 32'h6, RESP_OKAY);
    axi_write(7'h2c, 32'h4, 4'hf, RESP_OKAY);
    axi_read(7'h2c, 32'h2, RESP_OKAY);
    core_ready = 1'b1;

    // Strobes and error responses
    axi_write(7'h04, 32'h0, 4'hf, RESP_OKAY);
    axi_write(7'h04, 32'hffffffff, 4'h3, RESP_OKAY);
    axi_read(7'h04, 32'h0000ffff, RESP_OKAY);
    axi_write(7'h30, 32'hdeadbeef, 4'hf, RESP_SLVERR);
    axi_read(7'h30, 32'h874d6191, RESP_OKAY);
    axi_read(7'h40, 32'h0, RESP_SLVERR);
    axi_write(7'h44, 32'h12345678, 4'hf, RESP_SLVERR);

    // Start coincident with a result strobe: result latched, result_valid cleared
    n0 = next_cnt;
    bq.push_back(RESP_OKAY);
    s_axi.awaddr = 7'h00; s_axi.wdata = 32'h1; s_axi.wstrb = 4'hf;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b1;
    core_result = RES2; core_result_valid = 1'b1;
    #1;
    check("coinc_start_accept", s_axi.awready, 1);
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; core_result_valid = 1'b0;
    @(posedge aclk); #1;
    check("coinc_start_pulse", next_cnt - n0, 1);
    axi_read(7'h2c, 32'h1, RESP_OKAY);
    axi_read(7'h30, 32'h00112233, RESP_OKAY);

    // Result strobe coincident with RESULT read acceptance returns old value
    begin
      rd_exp_t e;
      e.data = 32'h00112233; e.resp = RESP_OKAY;
      rq.push_back(e);
    end
    s_axi.araddr = 7'h30; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
    core_result = RES3; core_result_valid = 1'b1;
    #1;
    check("coinc_read_accept", s_axi.arready, 1);
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0; core_result_valid = 1'b0;
    check("coinc_read_rvalid", s_axi.rvalid, 1);
    s_axi.rready = 1'b1;
    @(posedge aclk); #1;
    s_axi.rready = 1'b0;
    axi_read(7'h30, 32'hdeadbeef, RESP_OKAY);

    // B backpressure: bvalid held, second pair blocked until B completes
    bq.push_back(RESP_OKAY);
    bq.push_back(RESP_OKAY);
    s_axi.awaddr = 7'h08; s_axi.wdata = 32'ha5a50001; s_axi.wstrb = 4'hf;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
    #1;
    check("bp_first_accept", s_axi.awready, 1);
    @(posedge aclk); #1;
    s_axi.awaddr = 7'h0c; s_axi.wdata = 32'ha5a50002;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid_hold", s_axi.bvalid, 1);
      check("bp_second_blocked", s_axi.awready, 0);
      @(posedge aclk); #1;
    end
    s_axi.bready = 1'b1;
    @(posedge aclk); #2;
    check("bp_second_accept", s_axi.awready, 1);
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    check("bp_second_bvalid", s_axi.bvalid, 1);
    @(posedge aclk); #1;
    axi_read(7'h08, 32'ha5a50001, RESP_OKAY);
    axi_read(7'h0c, 32'ha5a50002, RESP_OKAY);

    // R backpressure: rdata stable while rready low
    begin
      rd_exp_t e;
      e.data = 32'h28aed2a6; e.resp = RESP_OKAY;
      rq.push_back(e);
    end
    s_axi.araddr = 7'h18; s_axi.arvalid = 1'b1; s_axi.rready = 1'b0;
    #1;
    check("rbp_accept", s_axi.arready, 1);
    @(posedge aclk); #1;
    s_axi.arvalid = 1'b0;
    s_axi.araddr = 7'h30;
    for (int i = 0; i < 4; i++) begin
      check("rbp_rvalid_hold", s_axi.rvalid, 1);
      check("rbp_rdata_hold", s_axi.rdata, 32'h28aed2a6);
      @(posedge aclk); #1;
    end
    s_axi.rready = 1'b1;
    @(posedge aclk); #1;
    s_axi.rready = 1'b0;

    // AW presented three cycles before W
    bq.push_back(RESP_OKAY);
    s_axi.awaddr = 7'h10; s_axi.wdata = 32'h0badf00d; s_axi.wstrb = 4'hf;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("aw_only_wait", s_axi.awready, 0);
      @(posedge aclk); #2;
    end
    s_axi.wvalid = 1'b1;
    #1;
    check("aw_w_accept", s_axi.awready && s_axi.wready, 1);
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    check("aw_w_bvalid", s_axi.bvalid, 1);
    @(posedge aclk); #1;
    axi_read(7'h10, 32'h0badf00d, RESP_OKAY);

    // Reset while bvalid is pending
    axi_write(7'h24, 32'h12345678, 4'hf, RESP_OKAY);
    check("nonce_loaded", core_nonce, 64'h12345678_00000000);
    core_ready = 1'b0;
    axi_write(7'h00, 32'h1, 4'hf, RESP_OKAY);
    core_ready = 1'b1;
    s_axi.awaddr = 7'h14; s_axi.wdata = 32'hffffffff; s_axi.wstrb = 4'hf;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.bready = 1'b0;
    #1;
    @(posedge aclk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
    check("rmid_bvalid_set", s_axi.bvalid, 1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("rmid_bvalid", s_axi.bvalid, 0);
    check("rmid_rvalid", s_axi.rvalid, 0);
    check("rmid_core_key", core_key, 0);
    check("rmid_core_nonce", core_nonce, 0);
    check("rmid_core_block", core_block, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    axi_read(7'h2c, 32'h1, RESP_OKAY);
    axi_read(7'h30, 32'h0, RESP_OKAY);

    repeat (2) @(posedge aclk);
    #1;
    check("b_queue_empty", bq.size(), 0);
    check("r_queue_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
